// File: rtl/sort_sched_pkg.sv
// Shared types and defaults for the sort job scheduler: FSM state encoding,
// default sizing and a lane popcount helper.
package sort_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Default sizing; the top exposes these as overridable parameters.
    localparam int SORT_NUM_REQ  = 4;
    localparam int SORT_MAX_LEN  = 16;
    localparam int SORT_DATA_W   = $clog2(SORT_MAX_LEN);
    localparam int SORT_OUT_PORT = 2;
    localparam int SORT_TIMEOUT  = 4096;

    localparam int ID_W  = $clog2(SORT_NUM_REQ);
    localparam int CNT_W = $clog2(SORT_MAX_LEN + 1);

    // Number of set bits; callers zero-extend their lane vector to 64 bits.
    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sort_rr_arbiter.sv
// Round-robin pick: the first active request at or after the pointer wins.
// Purely combinational; the top registers the result at grant time.
module sort_rr_arbiter
    import sort_sched_pkg::*;
#(
    parameter int NUM_REQ = SORT_NUM_REQ,
    parameter int ID_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_BITS-1:0] ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_BITS-1:0] gnt_id,
    output logic               any_req
);

    assign any_req = |req;

    // Walk offsets from farthest to nearest so the nearest active request wins.
    always_comb begin
        gnt_id = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                gnt_id = ID_BITS'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign gnt[gi] = any_req && (gnt_id == ID_BITS'(gi));
        end
    endgenerate

endmodule

// File: rtl/sort_job_scheduler.sv
// Time-shares one sort engine between NUM_REQ requesters, one frame per job.
// IDLE grants round-robin, FEED streams the owner's keys into the engine and
// marks the final key with done, DRAIN returns the engine output tagged with
// the owner's ID and checks that the returned key count matches.
module sort_job_scheduler
    import sort_sched_pkg::*;
#(
    parameter int NUM_REQ    = SORT_NUM_REQ,
    parameter int DATA_WIDTH = SORT_DATA_W,
    parameter int MAX_LEN    = SORT_MAX_LEN,
    parameter int OUT_PORT   = SORT_OUT_PORT,
    parameter int TIMEOUT    = SORT_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_vld_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]             req_last_i,
    input  logic [NUM_REQ-1:0]             req_mode_i,
    output logic [NUM_REQ-1:0]             req_rdy_o,
    output logic                           sort_vld_o,
    output logic [DATA_WIDTH-1:0]          sort_data_o,
    output logic                           sort_done_o,
    output logic                           sort_mode_o,
    input  logic [OUT_PORT-1:0]            sort_out_vld_i,
    input  logic [OUT_PORT*DATA_WIDTH-1:0] sort_out_data_i,
    input  logic                           sort_out_done_i,
    output logic [OUT_PORT-1:0]            rsp_vld_o,
    output logic [OUT_PORT*DATA_WIDTH-1:0] rsp_data_o,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id_o,
    output logic                           rsp_done_o,
    output logic                           err_o,
    output logic                           busy_o
);

    localparam int ID_BITS  = $clog2(NUM_REQ);
    localparam int CNT_BITS = $clog2(MAX_LEN + 1);
    localparam int TMR_BITS = $clog2(TIMEOUT + 1);

    localparam logic [CNT_BITS-1:0] LEN_LAST  = CNT_BITS'(MAX_LEN - 1);
    localparam logic [CNT_BITS-1:0] LEN_MAX   = CNT_BITS'(MAX_LEN);
    localparam logic [TMR_BITS-1:0] TMR_LAST  = TMR_BITS'(TIMEOUT - 1);
    localparam logic [TMR_BITS-1:0] TMR_MAX   = TMR_BITS'(TIMEOUT);

    state_t               state_reg;
    logic [ID_BITS-1:0]   gnt_id_reg;
    logic [ID_BITS-1:0]   ptr_reg;
    logic [CNT_BITS-1:0]  len_cnt_reg;
    logic [CNT_BITS-1:0]  out_cnt_reg;
    logic [TMR_BITS-1:0]  timer_reg;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [ID_BITS-1:0]   arb_id;
    logic                 arb_any;

    logic [DATA_WIDTH-1:0] key_sel;
    logic                  key_take;
    logic                  key_final;
    logic [ID_BITS-1:0]    ptr_next;
    logic [CNT_BITS-1:0]   len_inc;
    logic [CNT_BITS-1:0]   out_cnt_next;
    logic [TMR_BITS-1:0]   timer_inc;
    logic [6:0]            beat_cnt;
    int                    out_sum;

    sort_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_BITS (ID_BITS)
    ) u_arb (
        .req     (req_vld_i),
        .ptr     (ptr_reg),
        .gnt     (arb_gnt),
        .gnt_id  (arb_id),
        .any_req (arb_any)
    );

    // rdy is only ever set for the owner while in FEED, so it doubles as the accept qualifier.
    assign key_sel   = req_data_i[gnt_id_reg*DATA_WIDTH +: DATA_WIDTH];
    assign key_take  = (state_reg == FEED) && req_vld_i[gnt_id_reg] && req_rdy_o[gnt_id_reg];
    assign key_final = req_last_i[gnt_id_reg] || (len_cnt_reg == LEN_LAST);
    assign ptr_next  = (gnt_id_reg == ID_BITS'(NUM_REQ - 1)) ? '0 : gnt_id_reg + ID_BITS'(1);
    assign len_inc   = (len_cnt_reg == LEN_MAX) ? len_cnt_reg : len_cnt_reg + CNT_BITS'(1);
    assign timer_inc = (timer_reg == TMR_MAX) ? timer_reg : timer_reg + TMR_BITS'(1);
    assign beat_cnt  = popcount(64'(sort_out_vld_i));
    assign busy_o    = (state_reg != IDLE);

    // Saturating running total of keys returned by the engine, including this cycle's lanes.
    always_comb begin
        out_sum      = int'(out_cnt_reg) + int'(beat_cnt);
        out_cnt_next = (out_sum > MAX_LEN) ? LEN_MAX : CNT_BITS'(out_sum);
    end

    // Job FSM with its counters and the registered engine/requester-facing outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            gnt_id_reg  <= '0;
            ptr_reg     <= '0;
            len_cnt_reg <= '0;
            out_cnt_reg <= '0;
            timer_reg   <= '0;
            req_rdy_o   <= '0;
            sort_vld_o  <= 1'b0;
            sort_data_o <= '0;
            sort_done_o <= 1'b0;
            sort_mode_o <= 1'b0;
            rsp_vld_o   <= '0;
            rsp_data_o  <= '0;
            rsp_id_o    <= '0;
            rsp_done_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            sort_vld_o  <= 1'b0;
            sort_done_o <= 1'b0;
            rsp_vld_o   <= '0;
            rsp_done_o  <= 1'b0;
            err_o       <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        gnt_id_reg  <= arb_id;
                        sort_mode_o <= req_mode_i[arb_id];
                        req_rdy_o   <= arb_gnt;
                        len_cnt_reg <= '0;
                        state_reg   <= FEED;
                    end
                end

                FEED: begin
                    if (key_take) begin
                        sort_data_o <= key_sel;
                        sort_vld_o  <= 1'b1;
                        len_cnt_reg <= len_inc;
                        if (key_final) begin
                            sort_done_o <= 1'b1;
                            req_rdy_o   <= '0;
                            out_cnt_reg <= '0;
                            timer_reg   <= '0;
                            rsp_id_o    <= gnt_id_reg;
                            // A frame cut at capacity is still sorted, but flagged.
                            err_o       <= !req_last_i[gnt_id_reg];
                            state_reg   <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    rsp_vld_o   <= sort_out_vld_i;
                    rsp_data_o  <= sort_out_data_i;
                    out_cnt_reg <= out_cnt_next;
                    timer_reg   <= timer_inc;
                    if (sort_out_done_i) begin
                        rsp_done_o  <= 1'b1;
                        err_o       <= (out_cnt_next != len_cnt_reg);
                        ptr_reg     <= ptr_next;
                        sort_mode_o <= 1'b0;
                        state_reg   <= IDLE;
                    end else if (timer_reg == TMR_LAST) begin
                        // Engine never signalled completion: close the job anyway.
                        rsp_done_o  <= 1'b1;
                        err_o       <= 1'b1;
                        ptr_reg     <= ptr_next;
                        sort_mode_o <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_job_scheduler.sv
// Bench for sort_job_scheduler: randomized requester frames, a behavioural
// sort-engine model and a scoreboard that derives each job's expected result
// from the frame that was offered.
module tb_sort_job_scheduler;

    localparam int NR = 4;
    localparam int DW = 4;
    localparam int ML = 16;
    localparam int OP = 2;
    localparam int TO = 300;
    localparam int FMAX = ML + 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NR-1:0]        req_vld_i = '0;
    logic [NR*DW-1:0]     req_data_i = '0;
    logic [NR-1:0]        req_last_i = '0;
    logic [NR-1:0]        req_mode_i = '0;
    logic [NR-1:0]        req_rdy_o;
    logic                 sort_vld_o;
    logic [DW-1:0]        sort_data_o;
    logic                 sort_done_o;
    logic                 sort_mode_o;
    logic [OP-1:0]        sort_out_vld_i = '0;
    logic [OP*DW-1:0]     sort_out_data_i = '0;
    logic                 sort_out_done_i = 1'b0;
    logic [OP-1:0]        rsp_vld_o;
    logic [OP*DW-1:0]     rsp_data_o;
    logic [1:0]           rsp_id_o;
    logic                 rsp_done_o;
    logic                 err_o;
    logic                 busy_o;

    always #5 clk = ~clk;

    sort_job_scheduler #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_LEN    (ML),
        .OUT_PORT   (OP),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_vld_i       (req_vld_i),
        .req_data_i      (req_data_i),
        .req_last_i      (req_last_i),
        .req_mode_i      (req_mode_i),
        .req_rdy_o       (req_rdy_o),
        .sort_vld_o      (sort_vld_o),
        .sort_data_o     (sort_data_o),
        .sort_done_o     (sort_done_o),
        .sort_mode_o     (sort_mode_o),
        .sort_out_vld_i  (sort_out_vld_i),
        .sort_out_data_i (sort_out_data_i),
        .sort_out_done_i (sort_out_done_i),
        .rsp_vld_o       (rsp_vld_o),
        .rsp_data_o      (rsp_data_o),
        .rsp_id_o        (rsp_id_o),
        .rsp_done_o      (rsp_done_o),
        .err_o           (err_o),
        .busy_o          (busy_o)
    );

    int checks   = 0;
    int failures = 0;

    // requester frames
    int  fdata [NR][FMAX];
    int  flen  [NR];
    int  fidx  [NR];
    bit  flast [NR];
    bit  bubbles = 1'b0;

    // engine model state and knobs
    int  eng_q[$];
    bit  eng_pend = 1'b0;
    int  eng_delay = 0;
    bit  eng_withhold = 1'b0;
    int  eng_drop = 0;

    // monitor state for the current job
    int  got_q[$];
    int  exp_q[$];
    int  got_id = 0;
    bit  id_seen = 1'b0;
    bit  id_incons = 1'b0;
    int  err_cnt = 0;
    int  done_cnt = 0;
    bit  err_at_done = 1'b0;
    int  sd_cnt = 0;
    int  sd_key = -1;
    int  multihot = 0;
    int  cyc = 0;
    int  sd_cyc = 0;
    int  done_cyc = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void eng_sort(input bit desc);
        int t;
        for (int i = 0; i < eng_q.size(); i++) begin
            for (int j = 0; j + 1 < eng_q.size() - i; j++) begin
                if (desc ? (eng_q[j] < eng_q[j+1]) : (eng_q[j] > eng_q[j+1])) begin
                    t = eng_q[j];
                    eng_q[j] = eng_q[j+1];
                    eng_q[j+1] = t;
                end
            end
        end
    endfunction

    // Monitor, engine model and requester drivers, all acting on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (sort_done_o) begin
                sd_cnt++;
                sd_key = int'(sort_data_o);
                sd_cyc = cyc;
            end
            for (int l = 0; l < OP; l++) begin
                if (rsp_vld_o[l]) begin
                    if (!id_seen) begin
                        got_id  = int'(rsp_id_o);
                        id_seen = 1'b1;
                    end else if (int'(rsp_id_o) != got_id) begin
                        id_incons = 1'b1;
                    end
                    got_q.push_back(int'(rsp_data_o[l*DW +: DW]));
                end
            end
            if (err_o) err_cnt++;
            if (rsp_done_o) begin
                done_cnt++;
                err_at_done = err_o;
                done_cyc = cyc;
            end
            if ($countones(req_rdy_o) > 1) multihot++;
        end

        sort_out_vld_i  = '0;
        sort_out_data_i = '0;
        sort_out_done_i = 1'b0;
        if (!rst) begin
            eng_q.delete();
            eng_pend = 1'b0;
        end else if (sort_vld_o) begin
            eng_q.push_back(int'(sort_data_o));
            if (sort_done_o) begin
                eng_sort(sort_mode_o);
                for (int d = 0; d < eng_drop; d++) begin
                    if (eng_q.size() > 0) void'(eng_q.pop_back());
                end
                eng_pend  = 1'b1;
                eng_delay = 2;
            end
        end else if (eng_pend) begin
            if (eng_delay > 0) begin
                eng_delay--;
            end else begin
                for (int l = 0; l < OP; l++) begin
                    if (eng_q.size() > 0) begin
                        sort_out_vld_i[l] = 1'b1;
                        sort_out_data_i[l*DW +: DW] = DW'(eng_q.pop_front());
                    end
                end
                if (eng_q.size() == 0) begin
                    eng_pend = 1'b0;
                    sort_out_done_i = !eng_withhold;
                end
            end
        end

        for (int r = 0; r < NR; r++) begin
            if (rst && fidx[r] < flen[r]) begin
                req_vld_i[r] = !bubbles || ($urandom_range(0, 3) != 0);
                req_data_i[r*DW +: DW] = DW'(fdata[r][fidx[r]]);
                req_last_i[r] = flast[r] && (fidx[r] == flen[r] - 1);
                // rdy is stable until the next rising edge, which takes this key.
                if (req_vld_i[r] && req_rdy_o[r]) fidx[r]++;
            end else begin
                req_vld_i[r]  = 1'b0;
                req_last_i[r] = 1'b0;
            end
        end
    end

    task automatic clear_mon();
        got_q.delete();
        id_seen = 1'b0;
        id_incons = 1'b0;
        err_cnt = 0;
        done_cnt = 0;
        err_at_done = 1'b0;
        sd_cnt = 0;
        sd_key = -1;
    endtask

    task automatic load(input int r, input int n, input bit has_last, input bit mode);
        for (int i = 0; i < n; i++) fdata[r][i] = int'($urandom_range(0, (1 << DW) - 1));
        flen[r]  = n;
        fidx[r]  = 0;
        flast[r] = has_last;
        req_mode_i[r] = mode;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int r = 0; r < NR; r++) begin
            flen[r] = 0;
            fidx[r] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        clear_mon();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_done_seen"}, int'(done_cnt != 0), 1);
    endtask

    // Expected response: the accepted keys in value order (counting sort over the key range).
    task automatic build_exp(input int r, input int n, input bit desc, input int drop);
        exp_q.delete();
        for (int k = 0; k < (1 << DW); k++) begin
            int v;
            v = desc ? ((1 << DW) - 1 - k) : k;
            for (int i = 0; i < n; i++) begin
                if (fdata[r][i] == v) exp_q.push_back(v);
            end
        end
        for (int d = 0; d < drop; d++) void'(exp_q.pop_back());
    endtask

    task automatic check_job(input string tag, input int r, input int n, input bit desc,
                             input int drop, input int exp_err, input bit exp_err_done);
        build_exp(r, n, desc, drop);
        chk({tag, "_rsp_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_key%0d", tag, i), got_q[i], exp_q[i]);
        end
        if (exp_q.size() > 0) chk({tag, "_id"}, got_id, r);
        chk({tag, "_id_stable"}, int'(id_incons), 0);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_err_cnt"}, err_cnt, exp_err);
        chk({tag, "_err_at_done"}, int'(err_at_done), int'(exp_err_done));
        $display("job %s req=%0d keys=%0d mode=%0d rsp=%0d err=%0d", tag, r, n, desc,
                 got_q.size(), err_cnt);
        clear_mon();
    endtask

    initial begin
        int r, n, left, lat, wait_n;
        bit m;
        for (int i = 0; i < NR; i++) begin
            flen[i] = 0;
            fidx[i] = 0;
            flast[i] = 1'b0;
        end

        // reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_rdy", int'(req_rdy_o), 0);
        chk("rst_sort_outs", int'({sort_vld_o, sort_done_o, sort_mode_o, sort_data_o}), 0);
        chk("rst_rsp_outs", int'({rsp_vld_o, rsp_done_o, err_o, rsp_id_o}), 0);
        do_reset();

        // directed job: req0 sends 5,1,4,2 with mode 1
        fdata[0][0] = 5; fdata[0][1] = 1; fdata[0][2] = 4; fdata[0][3] = 2;
        flen[0] = 4; fidx[0] = 0; flast[0] = 1'b1; req_mode_i[0] = 1'b1;
        wait_done("dir", 200);
        chk("dir_done_key", sd_key, 2);
        chk("dir_sd_cnt", sd_cnt, 1);
        chk("dir_idle", int'(busy_o), 0);
        check_job("dir", 0, 4, 1'b1, 0, 0, 1'b0);

        // req1 and req3 together right after reset: rr starts at 0 so req1 then req3
        do_reset();
        bubbles = 1'b1;
        load(1, int'($urandom_range(1, 8)), 1'b1, 1'($urandom_range(0, 1)));
        load(3, int'($urandom_range(1, 8)), 1'b1, 1'($urandom_range(0, 1)));
        wait_done("pair1", 400);
        check_job("pair1", 1, flen[1], req_mode_i[1], 0, 0, 1'b0);
        wait_done("pair3", 400);
        check_job("pair3", 3, flen[3], req_mode_i[3], 0, 0, 1'b0);

        // overflow: req2 offers MAX_LEN+3 keys with no last
        m = 1'($urandom_range(0, 1));
        load(2, ML + 3, 1'b0, m);
        wait_n = 0;
        while (sd_cnt == 0 && wait_n < 400) begin
            @(negedge clk);
            #1;
            wait_n++;
        end
        chk("ovf_sd_seen", sd_cnt, 1);
        left = flen[2] - fidx[2];
        flen[2] = fidx[2];
        chk("ovf_left", left, 3);
        chk("ovf_rdy_drop", int'(req_rdy_o), 0);
        chk("ovf_done_key", sd_key, fdata[2][ML-1]);
        wait_done("ovf", 400);
        check_job("ovf", 2, ML, m, 0, 1, 1'b0);

        // randomized single-owner jobs
        for (int j = 0; j < 10; j++) begin
            r = int'($urandom_range(0, NR - 1));
            n = int'($urandom_range(1, ML));
            m = 1'($urandom_range(0, 1));
            load(r, n, 1'b1, m);
            wait_done($sformatf("rnd%0d", j), 600);
            check_job($sformatf("rnd%0d", j), r, n, m, 0, 0, 1'b0);
        end

        // engine returns one key short on a 4-key job
        eng_drop = 1;
        m = 1'($urandom_range(0, 1));
        load(1, 4, 1'b1, m);
        wait_done("short", 200);
        check_job("short", 1, 4, m, 1, 1, 1'b1);
        eng_drop = 0;

        // engine never signals done: drain times out
        eng_withhold = 1'b1;
        m = 1'($urandom_range(0, 1));
        n = int'($urandom_range(2, 6));
        load(3, n, 1'b1, m);
        wait_done("tmo", TO + 200);
        lat = done_cyc - sd_cyc;
        chk("tmo_latency_ok", int'(lat >= TO && lat <= TO + 1), 1);
        chk("tmo_idle", int'(busy_o), 0);
        check_job("tmo", 3, n, m, 0, 1, 1'b1);
        eng_withhold = 1'b0;
        load(0, 5, 1'b1, 1'b0);
        wait_done("after_tmo", 300);
        check_job("after_tmo", 0, 5, 1'b0, 0, 0, 1'b0);

        // reset in the middle of FEED after three keys
        bubbles = 1'b0;
        load(0, 8, 1'b1, 1'b1);
        wait_n = 0;
        while (fidx[0] < 3 && wait_n < 100) begin
            @(negedge clk);
            #1;
            wait_n++;
        end
        chk("mid_three_keys", fidx[0], 3);
        @(posedge clk);
        #2;
        rst = 1'b0;
        flen[0] = 0;
        fidx[0] = 0;
        #1;
        chk("mid_busy", int'(busy_o), 0);
        chk("mid_rdy", int'(req_rdy_o), 0);
        chk("mid_sort_outs", int'({sort_vld_o, sort_done_o, sort_mode_o, sort_data_o}), 0);
        chk("mid_rsp_outs", int'({rsp_vld_o, rsp_done_o, err_o, rsp_id_o}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        clear_mon();
        bubbles = 1'b1;
        load(0, 6, 1'b1, 1'b0);
        wait_done("post_rst", 300);
        check_job("post_rst", 0, 6, 1'b0, 0, 0, 1'b0);

        chk("rdy_never_multihot", multihot, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
